uart_fifo_core: RTL

UART_FIFO_CORE -- requirements
Module: uart_fifo_core

---
 rtl/uart_fifo_core.sv | 372 +++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_fifo_core.sv
// uart_fifo_core: UART transmitter and receiver, each fed/drained by a
// first-word-fall-through FIFO, with sticky line-error flags and an
// internal loopback path for self-test.
module uart_fifo_core #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 loopback,
  input  logic                 tx_wr_en,
  input  logic [DATA_BITS-1:0] tx_wr_data,
  output logic                 tx_full,
  output logic [CW-1:0]        tx_count,
  input  logic                 rx_rd_en,
  output logic [DATA_BITS-1:0] rx_rd_data,
  output logic                 rx_empty,
  output logic [CW-1:0]        rx_count,
  input  logic                 uart_rx,
  output logic                 uart_tx,
  output logic                 tx_busy,
  output logic                 rx_busy,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun_error,
  input  logic                 error_clear
);

  localparam int DIV   = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W = $clog2(DIV + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] BAUD_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] BAUD_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_M1    = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_BIT  = CNT_W'(DIV / 2);
  localparam logic [CW-1:0]    LVL_ZERO  = CW'(0);
  localparam logic [CW-1:0]    LVL_ONE   = CW'(1);
  localparam logic [CW-1:0]    LVL_FULL  = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0]    PTR_ZERO  = AW'(0);
  localparam logic [AW-1:0]    PTR_ONE   = AW'(1);
  localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [1:0]       LAST_STOP = 2'(STOP_BITS - 1);
  localparam logic [DATA_BITS-1:0] DATA_ZERO = {DATA_BITS{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // Parity bit for a payload: even parity is the plain XOR reduction.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] data);
    return (^data) ^ (PARITY_ODD != 0);
  endfunction

  // TX FIFO
  logic [DATA_BITS-1:0] tx_mem_q [FIFO_DEPTH];
  logic [AW-1:0]        tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [CW-1:0]        tx_level_q, tx_level_d;
  logic                 tx_push_s, tx_pop_s;
  logic [DATA_BITS-1:0] tx_head_s;

  // RX FIFO
  logic [DATA_BITS-1:0] rx_mem_q [FIFO_DEPTH];
  logic [AW-1:0]        rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [CW-1:0]        rx_level_q, rx_level_d;
  logic                 rx_push_s, rx_pop_s;

  // TX engine
  state_e               tx_state_q, tx_state_d;
  logic [CNT_W-1:0]     tx_baud_q, tx_baud_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic [1:0]           tx_stop_q, tx_stop_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 uart_tx_q, uart_tx_d;

  // RX engine
  logic                 rx_sync1_q, rx_sync2_q, rx_prev_q;
  logic                 line_s;
  state_e               rx_state_q, rx_state_d;
  logic [CNT_W-1:0]     rx_baud_q, rx_baud_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic [1:0]           rx_stop_q, rx_stop_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;

  // Sticky errors
  logic perr_q, perr_d, ferr_q, ferr_d, oerr_q, oerr_d;
  logic perr_set_s, ferr_set_s, oerr_set_s;

  assign tx_head_s = tx_mem_q[tx_rptr_q];
  // Loopback is inserted after the synchronizer so it adds no latency.
  assign line_s    = loopback ? uart_tx_q : rx_sync2_q;

  // FIFO pointer and occupancy bookkeeping for both directions.
  always_comb begin
    tx_push_s = tx_wr_en && (tx_level_q != LVL_FULL);
    rx_pop_s  = rx_rd_en && (rx_level_q != LVL_ZERO);
    tx_wptr_d = tx_push_s ? (tx_wptr_q + PTR_ONE) : tx_wptr_q;
    tx_rptr_d = tx_pop_s  ? (tx_rptr_q + PTR_ONE) : tx_rptr_q;
    rx_wptr_d = rx_push_s ? (rx_wptr_q + PTR_ONE) : rx_wptr_q;
    rx_rptr_d = rx_pop_s  ? (rx_rptr_q + PTR_ONE) : rx_rptr_q;
    case ({tx_push_s, tx_pop_s})
      2'b10:   tx_level_d = tx_level_q + LVL_ONE;
      2'b01:   tx_level_d = tx_level_q - LVL_ONE;
      default: tx_level_d = tx_level_q;
    endcase
    case ({rx_push_s, rx_pop_s})
      2'b10:   rx_level_d = rx_level_q + LVL_ONE;
      2'b01:   rx_level_d = rx_level_q - LVL_ONE;
      default: rx_level_d = rx_level_q;
    endcase
  end

  // TX frame sequencer; the next frame is loaded straight from STOP to stay gap-free.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_stop_d  = tx_stop_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    uart_tx_d  = uart_tx_q;
    tx_pop_s   = 1'b0;
    case (tx_state_q)
      ST_IDLE: begin
        if (enable && (tx_level_q != LVL_ZERO)) begin
          tx_pop_s   = 1'b1;
          tx_state_d = ST_START;
          tx_baud_d  = BAUD_ZERO;
          tx_shift_d = tx_head_s;
          tx_par_d   = parity_of(tx_head_s);
          uart_tx_d  = 1'b0;
        end else begin
          uart_tx_d  = 1'b1;
        end
      end
      ST_START: begin
        if (tx_baud_q == DIV_M1) begin
          tx_baud_d  = BAUD_ZERO;
          tx_bit_d   = 4'd0;
          tx_state_d = ST_DATA;
          uart_tx_d  = tx_shift_q[0];
        end else begin
          tx_baud_d  = tx_baud_q + BAUD_ONE;
        end
      end
      ST_DATA: begin
        if (tx_baud_q == DIV_M1) begin
          tx_baud_d = BAUD_ZERO;
          if (tx_bit_q == LAST_DATA) begin
            tx_stop_d = 2'd0;
            if (PARITY_EN != 0) begin
              tx_state_d = ST_PARITY;
              uart_tx_d  = tx_par_q;
            end else begin
              tx_state_d = ST_STOP;
              uart_tx_d  = 1'b1;
            end
          end else begin
            tx_bit_d   = tx_bit_q + 4'd1;
            tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
            uart_tx_d  = tx_shift_q[1];
          end
        end else begin
          tx_baud_d = tx_baud_q + BAUD_ONE;
        end
      end
      ST_PARITY: begin
        if (tx_baud_q == DIV_M1) begin
          tx_baud_d  = BAUD_ZERO;
          tx_stop_d  = 2'd0;
          tx_state_d = ST_STOP;
          uart_tx_d  = 1'b1;
        end else begin
          tx_baud_d  = tx_baud_q + BAUD_ONE;
        end
      end
      ST_STOP: begin
        if (tx_baud_q == DIV_M1) begin
          tx_baud_d = BAUD_ZERO;
          if (tx_stop_q == LAST_STOP) begin
            if (enable && (tx_level_q != LVL_ZERO)) begin
              tx_pop_s   = 1'b1;
              tx_state_d = ST_START;
              tx_shift_d = tx_head_s;
              tx_par_d   = parity_of(tx_head_s);
              uart_tx_d  = 1'b0;
            end else begin
              tx_state_d = ST_IDLE;
              uart_tx_d  = 1'b1;
            end
          end else begin
            tx_stop_d = tx_stop_q + 2'd1;
          end
        end else begin
          tx_baud_d = tx_baud_q + BAUD_ONE;
        end
      end
      default: begin
        tx_state_d = ST_IDLE;
        uart_tx_d  = 1'b1;
      end
    endcase
  end

  // RX frame sequencer: mid-bit sampling, glitch rejection, error detection and push.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_stop_d  = rx_stop_q;
    rx_shift_d = rx_shift_q;
    rx_push_s  = 1'b0;
    perr_set_s = 1'b0;
    ferr_set_s = 1'b0;
    oerr_set_s = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        if (enable && rx_prev_q && !line_s) begin
          // The first low clock counts as clock 0 of the start bit.
          rx_state_d = ST_START;
          rx_baud_d  = BAUD_ONE;
        end else begin
          rx_state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (rx_baud_q == HALF_BIT) begin
          rx_baud_d = BAUD_ZERO;
          rx_bit_d  = 4'd0;
          rx_state_d = line_s ? ST_IDLE : ST_DATA;
        end else begin
          rx_baud_d = rx_baud_q + BAUD_ONE;
        end
      end
      ST_DATA: begin
        if (rx_baud_q == DIV_M1) begin
          rx_baud_d  = BAUD_ZERO;
          rx_shift_d = {line_s, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == LAST_DATA) begin
            rx_stop_d  = 2'd0;
            rx_state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            rx_bit_d   = rx_bit_q + 4'd1;
          end
        end else begin
          rx_baud_d = rx_baud_q + BAUD_ONE;
        end
      end
      ST_PARITY: begin
        if (rx_baud_q == DIV_M1) begin
          rx_baud_d  = BAUD_ZERO;
          perr_set_s = (line_s != parity_of(rx_shift_q));
          rx_state_d = ST_STOP;
        end else begin
          rx_baud_d  = rx_baud_q + BAUD_ONE;
        end
      end
      ST_STOP: begin
        if (rx_baud_q == DIV_M1) begin
          rx_baud_d  = BAUD_ZERO;
          ferr_set_s = ~line_s;
          if (rx_stop_q == LAST_STOP) begin
            // Errored frames are still delivered; only a full FIFO drops them.
            rx_state_d = ST_IDLE;
            oerr_set_s = (rx_level_q == LVL_FULL);
            rx_push_s  = (rx_level_q != LVL_FULL);
          end else begin
            rx_stop_d  = rx_stop_q + 2'd1;
          end
        end else begin
          rx_baud_d = rx_baud_q + BAUD_ONE;
        end
      end
      default: begin
        rx_state_d = ST_IDLE;
      end
    endcase
  end

  // Sticky error flags; a coincident set beats error_clear.
  always_comb begin
    perr_d = perr_set_s ? 1'b1 : (error_clear ? 1'b0 : perr_q);
    ferr_d = ferr_set_s ? 1'b1 : (error_clear ? 1'b0 : ferr_q);
    oerr_d = oerr_set_s ? 1'b1 : (error_clear ? 1'b0 : oerr_q);
  end

  // FIFO storage; contents need no reset because the levels gate visibility.
  always_ff @(posedge clk) begin
    if (tx_push_s) tx_mem_q[tx_wptr_q] <= tx_wr_data;
    if (rx_push_s) rx_mem_q[rx_wptr_q] <= rx_shift_q;
  end

  // State register for every control flop, with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wptr_q  <= PTR_ZERO;
      tx_rptr_q  <= PTR_ZERO;
      tx_level_q <= LVL_ZERO;
      rx_wptr_q  <= PTR_ZERO;
      rx_rptr_q  <= PTR_ZERO;
      rx_level_q <= LVL_ZERO;
      tx_state_q <= ST_IDLE;
      tx_baud_q  <= BAUD_ZERO;
      tx_bit_q   <= 4'd0;
      tx_stop_q  <= 2'd0;
      tx_shift_q <= DATA_ZERO;
      tx_par_q   <= 1'b0;
      uart_tx_q  <= 1'b1;
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_baud_q  <= BAUD_ZERO;
      rx_bit_q   <= 4'd0;
      rx_stop_q  <= 2'd0;
      rx_shift_q <= DATA_ZERO;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      oerr_q     <= 1'b0;
    end else begin
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
      tx_level_q <= tx_level_d;
      rx_wptr_q  <= rx_wptr_d;
      rx_rptr_q  <= rx_rptr_d;
      rx_level_q <= rx_level_d;
      tx_state_q <= tx_state_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_stop_q  <= tx_stop_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      uart_tx_q  <= uart_tx_d;
      rx_sync1_q <= uart_rx;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= line_s;
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_stop_q  <= rx_stop_d;
      rx_shift_q <= rx_shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      oerr_q     <= oerr_d;
    end
  end

  assign uart_tx       = uart_tx_q;
  assign tx_full       = (tx_level_q == LVL_FULL);
  assign tx_count      = tx_level_q;
  assign rx_empty      = (rx_level_q == LVL_ZERO);
  assign rx_count      = rx_level_q;
  assign rx_rd_data    = (rx_level_q == LVL_ZERO) ? DATA_ZERO : rx_mem_q[rx_rptr_q];
  assign tx_busy       = (tx_state_q != ST_IDLE);
  assign rx_busy       = (rx_state_q != ST_IDLE);
  assign parity_error  = perr_q;
  assign framing_error = ferr_q;
  assign overrun_error = oerr_q;

endmodule
